// File: rtl/cv32e40p_x_arbiter.sv
// Shares one X-interface coprocessor between two cv32e40p cores, with lock-on-stall arbitration and in-order response routing.
// Define CV32E40P_X_ARB_FAIR_EN for round-robin arbitration; the default build uses fixed priority with core 0 first.
module cv32e40p_x_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             req_x_valid_i,
  output logic [1:0]             req_x_ready_o,
  input  logic [1:0][31:0]       req_x_instr_data_i,
  input  logic [1:0][2:0][31:0]  req_x_rs_i,
  input  logic [1:0][2:0]        req_x_rs_valid_i,
  output logic [1:0]             req_x_accept_o,
  output logic [1:0]             req_x_is_mem_op_o,
  output logic [1:0]             req_x_writeback_o,
  output logic [1:0]             req_x_rvalid_o,
  input  logic [1:0]             req_x_rready_i,
  output logic [4:0]             req_x_rd_o,
  output logic [31:0]            req_x_data_o,
  output logic                   req_x_dualwb_o,
  output logic                   req_x_type_o,
  output logic                   req_x_error_o,
  output logic                   x_valid_o,
  output logic [31:0]            x_instr_data_o,
  output logic [2:0][31:0]       x_rs_o,
  output logic [2:0]             x_rs_valid_o,
  input  logic                   x_ready_i,
  input  logic                   x_accept_i,
  input  logic                   x_is_mem_op_i,
  input  logic                   x_writeback_i,
  input  logic                   x_rvalid_i,
  output logic                   x_rready_o,
  input  logic [4:0]             x_rd_i,
  input  logic [31:0]            x_data_i,
  input  logic                   x_dualwb_i,
  input  logic                   x_type_i,
  input  logic                   x_error_i,
  output logic [$clog2(DEPTH):0] outstanding_o,
  output logic                   spurious_rsp_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {ARB, LOCK} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic [DEPTH-1:0]  owner_q, owner_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              spurious_q, spurious_d;
`ifdef CV32E40P_X_ARB_FAIR_EN
  logic              last_q, last_d;
`endif

  logic g, full, empty, hs, push, pop, head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = owner_q[rptr_q];

  // Grant selection: held while locked, otherwise chosen from current valids.
  always_comb begin
    g = 1'b0;
    if (state_q == LOCK) begin
      g = grant_q;
    end else if (req_x_valid_i[0] && req_x_valid_i[1]) begin
`ifdef CV32E40P_X_ARB_FAIR_EN
      g = ~last_q;
`else
      g = 1'b0;
`endif
    end else if (req_x_valid_i[1]) begin
      g = 1'b1;
    end
  end

  assign x_valid_o      = req_x_valid_i[g] && !full;
  assign x_instr_data_o = req_x_instr_data_i[g];
  assign x_rs_o         = req_x_rs_i[g];
  assign x_rs_valid_o   = req_x_rs_valid_i[g];
  assign hs             = x_valid_o && x_ready_i;
  assign push           = hs && x_accept_i && x_writeback_i;

  always_comb begin
    req_x_ready_o        = '0;
    req_x_accept_o       = '0;
    req_x_is_mem_op_o    = '0;
    req_x_writeback_o    = '0;
    req_x_ready_o[g]     = x_ready_i && !full;
    req_x_accept_o[g]    = x_accept_i;
    req_x_is_mem_op_o[g] = x_is_mem_op_i;
    req_x_writeback_o[g] = x_writeback_i;
  end

  // Responses go to the oldest owner; with no owner they are drained and flagged.
  always_comb begin
    req_x_rvalid_o = '0;
    x_rready_o     = 1'b1;
    if (!empty) begin
      req_x_rvalid_o[head] = x_rvalid_i;
      x_rready_o           = req_x_rready_i[head];
    end
  end

  assign pop = x_rvalid_i && x_rready_o && !empty;

  assign req_x_rd_o     = x_rd_i;
  assign req_x_data_o   = x_data_i;
  assign req_x_dualwb_o = x_dualwb_i;
  assign req_x_type_o   = x_type_i;
  assign req_x_error_o  = x_error_i;
  assign outstanding_o  = count_q;
  assign spurious_rsp_o = spurious_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    spurious_d = spurious_q | (x_rvalid_i & empty);
`ifdef CV32E40P_X_ARB_FAIR_EN
    last_d     = last_q;
    if (hs) last_d = g;
`endif
    case (state_q)
      ARB: begin
        if (x_valid_o && !x_ready_i) begin
          state_d = LOCK;
          grant_d = g;
        end
      end
      LOCK: begin
        if (hs) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    if (push) begin
      owner_d[wptr_q] = g;
      wptr_d          = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      grant_q    <= 1'b0;
      owner_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      spurious_q <= 1'b0;
`ifdef CV32E40P_X_ARB_FAIR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      spurious_q <= spurious_d;
`ifdef CV32E40P_X_ARB_FAIR_EN
      last_q     <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_cv32e40p_x_arbiter.sv
// Directed self-checking bench for cv32e40p_x_arbiter: arbitration, lock, owner FIFO, routing, spurious responses, reset.
module tb_cv32e40p_x_arbiter;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [1:0]            req_x_valid_i;
  logic [1:0]            req_x_ready_o;
  logic [1:0][31:0]      req_x_instr_data_i;
  logic [1:0][2:0][31:0] req_x_rs_i;
  logic [1:0][2:0]       req_x_rs_valid_i;
  logic [1:0]            req_x_accept_o, req_x_is_mem_op_o, req_x_writeback_o;
  logic [1:0]            req_x_rvalid_o;
  logic [1:0]            req_x_rready_i;
  logic [4:0]            req_x_rd_o;
  logic [31:0]           req_x_data_o;
  logic                  req_x_dualwb_o, req_x_type_o, req_x_error_o;
  logic                  x_valid_o;
  logic [31:0]           x_instr_data_o;
  logic [2:0][31:0]      x_rs_o;
  logic [2:0]            x_rs_valid_o;
  logic                  x_ready_i, x_accept_i, x_is_mem_op_i, x_writeback_i;
  logic                  x_rvalid_i;
  logic                  x_rready_o;
  logic [4:0]            x_rd_i;
  logic [31:0]           x_data_i;
  logic                  x_dualwb_i, x_type_i, x_error_i;
  logic [2:0]            outstanding_o;
  logic                  spurious_rsp_o;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [31:0] I0 = 32'h0000_00A0;
  localparam logic [31:0] I1 = 32'h0000_00B1;

  always #5 clk_i = ~clk_i;

  cv32e40p_x_arbiter #(.DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_x_valid_i(req_x_valid_i), .req_x_ready_o(req_x_ready_o),
    .req_x_instr_data_i(req_x_instr_data_i), .req_x_rs_i(req_x_rs_i),
    .req_x_rs_valid_i(req_x_rs_valid_i),
    .req_x_accept_o(req_x_accept_o), .req_x_is_mem_op_o(req_x_is_mem_op_o),
    .req_x_writeback_o(req_x_writeback_o),
    .req_x_rvalid_o(req_x_rvalid_o), .req_x_rready_i(req_x_rready_i),
    .req_x_rd_o(req_x_rd_o), .req_x_data_o(req_x_data_o),
    .req_x_dualwb_o(req_x_dualwb_o), .req_x_type_o(req_x_type_o), .req_x_error_o(req_x_error_o),
    .x_valid_o(x_valid_o), .x_instr_data_o(x_instr_data_o), .x_rs_o(x_rs_o),
    .x_rs_valid_o(x_rs_valid_o),
    .x_ready_i(x_ready_i), .x_accept_i(x_accept_i), .x_is_mem_op_i(x_is_mem_op_i),
    .x_writeback_i(x_writeback_i),
    .x_rvalid_i(x_rvalid_i), .x_rready_o(x_rready_o),
    .x_rd_i(x_rd_i), .x_data_i(x_data_i),
    .x_dualwb_i(x_dualwb_i), .x_type_i(x_type_i), .x_error_i(x_error_i),
    .outstanding_o(outstanding_o), .spurious_rsp_o(spurious_rsp_o)
  );

  task automatic clear_inputs();
    req_x_valid_i  = 2'b00;
    req_x_rready_i = 2'b11;
    x_ready_i      = 1'b0;
    x_accept_i     = 1'b0;
    x_is_mem_op_i  = 1'b0;
    x_writeback_i  = 1'b0;
    x_rvalid_i     = 1'b0;
    x_rd_i         = 5'd0;
    x_data_i       = 32'h0;
    x_dualwb_i     = 1'b0;
    x_type_i       = 1'b0;
    x_error_i      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (outstanding_o !== 3'd0) begin n_fails++; $display("FAIL reset_outstanding got %0d exp 0", outstanding_o); end
    n_checks++;
    if (spurious_rsp_o !== 1'b0) begin n_fails++; $display("FAIL reset_spurious got %b exp 0", spurious_rsp_o); end
    n_checks++;
    if (x_valid_o !== 1'b0 || req_x_rvalid_o !== 2'b00) begin
      n_fails++; $display("FAIL reset_idle x_valid %b rvalid %b exp 0 00", x_valid_o, req_x_rvalid_o);
    end
    req_x_valid_i = 2'b11;
    #1;
    n_checks++;
    if (x_instr_data_o !== I0 || req_x_ready_o !== 2'b00) begin
      n_fails++; $display("FAIL reset_first_grant instr %h ready %b exp %h 00", x_instr_data_o, req_x_ready_o, I0);
    end
    @(negedge clk_i);
  endtask

  task automatic test_arbitration();
    logic [31:0] exp_instr;
    logic [1:0]  exp_rdy;
    do_reset();
    req_x_valid_i = 2'b11; x_ready_i = 1'b1; x_accept_i = 1'b1; x_writeback_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef CV32E40P_X_ARB_FAIR_EN
      exp_instr = (i % 2 == 1) ? I1 : I0;
      exp_rdy   = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp_instr = I0;
      exp_rdy   = 2'b01;
`endif
      #1;
      n_checks++;
      if (x_instr_data_o !== exp_instr || req_x_ready_o !== exp_rdy || req_x_accept_o !== exp_rdy) begin
        n_fails++;
        $display("FAIL arb_grant[%0d] instr %h ready %b accept %b exp %h %b", i, x_instr_data_o, req_x_ready_o, req_x_accept_o, exp_instr, exp_rdy);
      end
      @(negedge clk_i);
    end
    req_x_valid_i = 2'b00;
    #1;
    n_checks++;
    if (outstanding_o !== 3'd4) begin n_fails++; $display("FAIL arb_outstanding got %0d exp 4", outstanding_o); end
  endtask

  task automatic test_lock();
    do_reset();
    x_accept_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_x_valid_i = (c == 0) ? 2'b01 : (c == 4) ? 2'b10 : 2'b11;
      x_ready_i     = (c >= 3);
      #1;
      n_checks++;
      if (x_instr_data_o !== ((c == 4) ? I1 : I0) || x_valid_o !== 1'b1) begin
        n_fails++; $display("FAIL lock0_cycle%0d instr %h valid %b exp %h 1", c, x_instr_data_o, x_valid_o, (c == 4) ? I1 : I0);
      end
      @(negedge clk_i);
    end
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req_x_valid_i = (c == 0) ? 2'b10 : (c == 3) ? 2'b01 : 2'b11;
      x_ready_i     = (c >= 2);
      #1;
      n_checks++;
      if (x_instr_data_o !== ((c == 3) ? I0 : I1) || req_x_ready_o !== ((c == 2) ? 2'b10 : (c == 3) ? 2'b01 : 2'b00)) begin
        n_fails++; $display("FAIL lock1_cycle%0d instr %h ready %b", c, x_instr_data_o, req_x_ready_o);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_full();
    do_reset();
    req_x_valid_i = 2'b01; x_ready_i = 1'b1; x_accept_i = 1'b1; x_writeback_i = 1'b1;
    repeat (4) @(negedge clk_i);
    x_rvalid_i = 1'b1; req_x_rready_i = 2'b01;
    #1;
    n_checks++;
    if (outstanding_o !== 3'd4) begin n_fails++; $display("FAIL full_count got %0d exp 4", outstanding_o); end
    n_checks++;
    if (x_valid_o !== 1'b0 || req_x_ready_o !== 2'b00) begin
      n_fails++; $display("FAIL full_block valid %b ready %b exp 0 00", x_valid_o, req_x_ready_o);
    end
    n_checks++;
    if (req_x_rvalid_o !== 2'b01 || x_rready_o !== 1'b1) begin
      n_fails++; $display("FAIL full_rsp rvalid %b rready %b exp 01 1", req_x_rvalid_o, x_rready_o);
    end
    @(negedge clk_i);
    x_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if (outstanding_o !== 3'd3 || x_valid_o !== 1'b1 || req_x_ready_o !== 2'b01) begin
      n_fails++; $display("FAIL full_reissue count %0d valid %b ready %b exp 3 1 01", outstanding_o, x_valid_o, req_x_ready_o);
    end
    @(negedge clk_i);
    req_x_valid_i = 2'b00;
    #1;
    n_checks++;
    if (outstanding_o !== 3'd4) begin n_fails++; $display("FAIL full_refill got %0d exp 4", outstanding_o); end
  endtask

  task automatic test_order();
    logic [1:0] exp_rv [4];
    logic       exp_rr [4];
    logic [4:0] rds    [4];
    logic [1:0] rrdy   [4];
    exp_rv = '{2'b10, 2'b01, 2'b01, 2'b10};
    exp_rr = '{1'b1, 1'b0, 1'b1, 1'b1};
    rds    = '{5'd5, 5'd6, 5'd6, 5'd7};
    rrdy   = '{2'b11, 2'b10, 2'b11, 2'b11};
    do_reset();
    x_ready_i = 1'b1; x_accept_i = 1'b1; x_writeback_i = 1'b1;
    req_x_valid_i = 2'b10; @(negedge clk_i);
    req_x_valid_i = 2'b01; @(negedge clk_i);
    req_x_valid_i = 2'b10; @(negedge clk_i);
    req_x_valid_i = 2'b00;
    x_rvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x_rd_i = rds[i]; x_data_i = 32'(rds[i]) + 32'h100; req_x_rready_i = rrdy[i];
      #1;
      n_checks++;
      if (req_x_rvalid_o !== exp_rv[i] || x_rready_o !== exp_rr[i] || req_x_rd_o !== rds[i]) begin
        n_fails++;
        $display("FAIL order_rsp%0d rvalid %b rready %b rd %0d exp %b %b %0d", i, req_x_rvalid_o, x_rready_o, req_x_rd_o, exp_rv[i], exp_rr[i], rds[i]);
      end
      @(negedge clk_i);
    end
    x_rvalid_i = 1'b0;
    #1;
    n_checks++;
    if (outstanding_o !== 3'd0 || spurious_rsp_o !== 1'b0) begin
      n_fails++; $display("FAIL order_drain count %0d spurious %b exp 0 0", outstanding_o, spurious_rsp_o);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    x_rvalid_i = 1'b1; req_x_rready_i = 2'b00;
    #1;
    n_checks++;
    if (x_rready_o !== 1'b1 || req_x_rvalid_o !== 2'b00) begin
      n_fails++; $display("FAIL spur_drop rready %b rvalid %b exp 1 00", x_rready_o, req_x_rvalid_o);
    end
    @(negedge clk_i);
    x_rvalid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (spurious_rsp_o !== 1'b1 || outstanding_o !== 3'd0) begin
      n_fails++; $display("FAIL spur_sticky flag %b count %0d exp 1 0", spurious_rsp_o, outstanding_o);
    end
    do_reset();
    #1;
    n_checks++;
    if (spurious_rsp_o !== 1'b0) begin n_fails++; $display("FAIL spur_clear got %b exp 0", spurious_rsp_o); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_x_valid_i = 2'b01; x_ready_i = 1'b1; x_accept_i = 1'b1; x_writeback_i = 1'b1;
    repeat (2) @(negedge clk_i);
    req_x_valid_i = 2'b10; x_ready_i = 1'b0; x_accept_i = 1'b0;
    @(negedge clk_i);
    req_x_valid_i = 2'b11;
    #1;
    n_checks++;
    if (outstanding_o !== 3'd2 || x_instr_data_o !== I1) begin
      n_fails++; $display("FAIL mid_pre count %0d instr %h exp 2 %h", outstanding_o, x_instr_data_o, I1);
    end
    #1 rst_i = 1'b1;
    #1;
    n_checks++;
    if (outstanding_o !== 3'd0) begin n_fails++; $display("FAIL mid_async_clear got %0d exp 0", outstanding_o); end
    @(negedge clk_i);
    rst_i = 1'b0; x_ready_i = 1'b1;
    #1;
    n_checks++;
    if (x_instr_data_o !== I0 || req_x_ready_o !== 2'b01) begin
      n_fails++; $display("FAIL mid_first_grant instr %h ready %b exp %h 01", x_instr_data_o, req_x_ready_o, I0);
    end
    @(negedge clk_i);
  endtask

  initial begin
    req_x_instr_data_i = '{I1, I0};
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) req_x_rs_i[c][k] = 32'(c * 16 + k);
      req_x_rs_valid_i[c] = 3'b111;
    end
    clear_inputs();
    rst_i = 1'b1;
    @(negedge clk_i);
    test_reset();
    test_arbitration();
    test_lock();
    test_full();
    test_order();
    test_spurious();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cv32e40p_x_arbiter.md
# cv32e40p_x_arbiter

Shares one X-interface coprocessor (accelerator/FPU-style offload unit) between two cv32e40p cores. It arbitrates the request channel between two requesters and holds the grant stable across back-pressure. It records the owner of every accepted writeback instruction in an in-order owner FIFO, and routes each response to the core that issued it. It sits between the cores' X-interface ports and the shared coprocessor's X-interface.

## Interface
- DEPTH, 4: maximum outstanding accepted-with-writeback instructions; power of 2, ≥2.
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- req_x_valid_i  in  [1:0]  per-core request valid.
- req_x_ready_o  out  [1:0]  per-core request ready.
- req_x_instr_data_i  in  [1:0][31:0]  per-core offloaded instruction.
- req_x_rs_i  in  [1:0][2:0][31:0]  per-core source operands.
- req_x_rs_valid_i  in  [1:0][2:0]  per-core operand valids.
- req_x_accept_o, req_x_is_mem_op_o, req_x_writeback_o  out  [1:0] each  per-core copies of the coprocessor decision.
- req_x_rvalid_o  out  [1:0]  per-core response valid.
- req_x_rready_i  in  [1:0]  per-core response ready.
- req_x_rd_o  out  5  response destination register, broadcast to both cores.
- req_x_data_o  out  32  response data, broadcast to both cores.
- req_x_dualwb_o, req_x_type_o, req_x_error_o  out  1 each  response flags, broadcast to both cores.
- x_valid_o, x_instr_data_o [31:0], x_rs_o [2:0][31:0], x_rs_valid_o [2:0]  out  coprocessor request channel.
- x_ready_i, x_accept_i, x_is_mem_op_i, x_writeback_i  in  1 each  coprocessor request reply.
- x_rvalid_i  in  1  coprocessor response valid.
- x_rready_o  out  1  coprocessor response ready.
- x_rd_i [4:0], x_data_i [31:0], x_dualwb_i, x_type_i, x_error_i  in  coprocessor response payload.
- outstanding_o  out  $clog2(DEPTH)+1  owner FIFO occupancy.
- spurious_rsp_o  out  1  sticky flag: a response arrived with no outstanding owner.

## Operation
- Request FSM, two states:
  - ARB: grant g is chosen combinationally from req_x_valid_i.
  - LOCK: g is held.
- Grant in ARB:
  - Only one core valid: grant that core.
  - Both valid: grant the core opposite to last_q.
- x_valid_o = req_x_valid_i[g] && !full.
- x_instr_data_o, x_rs_o, x_rs_valid_o = payload of core g.
- req_x_ready_o[g] = x_ready_i && !full. req_x_accept_o[g], req_x_is_mem_op_o[g], req_x_writeback_o[g] copy the coprocessor inputs.
- All per-core outputs of the non-granted core are 0.
- ARB→LOCK when x_valid_o && !x_ready_i. LOCK→ARB on x_valid_o && x_ready_i.
- Handshake in either state: last_q ← g.
- Handshake with x_accept_i && x_writeback_i: push g into the owner FIFO.
- Full = (count == DEPTH). While full, x_valid_o = 0. LOCK cannot be entered or held at full, because pushes only happen on a handshake.
- Response path:
  - FIFO non-empty: req_x_rvalid_o[head] = x_rvalid_i, x_rready_o = req_x_rready_i[head].
  - Pop on x_rvalid_i && x_rready_o.
- FIFO empty with x_rvalid_i = 1:
  - x_rready_o = 1 and the response is dropped.
  - req_x_rvalid_o = 0.
  - spurious_rsp_o ← 1.
- Push and pop in the same cycle: count is unchanged; both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Request and response paths are combinational: zero-cycle latency.
- FIFO push is visible to the response path one cycle after the handshake. A response in the same cycle as its own issue handshake is not supported and is treated as spurious.
- Reset values and reset behaviour:
  - FSM = ARB, last_q = 1 (core 0 is preferred first), FIFO empty, outstanding_o = 0, spurious_rsp_o = 0.
  - All registered state clears immediately on rst_i, including mid-transaction.
  - Combinational outputs follow from the cleared state.
- spurious_rsp_o clears only on reset.

## Configuration
- CV32E40P_X_ARB_FAIR_EN defined: round-robin arbitration via last_q, as described above.
- Undefined: fixed priority; core 0 always wins when both are valid. last_q is not implemented. Lock behaviour and the FIFO are unchanged.

## Test plan
- Both cores valid every cycle, x_ready_i = 1, accept = writeback = 1 → grants alternate 0,1,0,1 (FAIR_EN); all 0 without FAIR_EN.
- Core 0 valid, x_ready_i low for 3 cycles, core 1 raises valid in cycle 1 → x_instr_data_o stays core 0's; handshake in cycle 3; core 1 granted in cycle 4.
- Issue 4 accepted writeback instructions (DEPTH = 4) → outstanding_o = 4, x_valid_o = 0 on the 5th. One response pop → 5th instruction issues the next cycle.
- Owners 1,0,1 pushed; 3 responses with rd = 5,6,7 → req_x_rvalid_o pulses on 1,0,1 in order. Core 0 holding rready low stalls x_rready_o.
- x_rvalid_i with empty FIFO → x_rready_o = 1, req_x_rvalid_o = 00, spurious_rsp_o = 1 until rst_i.
- Assert rst_i with 2 outstanding and LOCK active → outstanding_o = 0, FSM = ARB, and core 0 is granted first after release.
